// File: rtl/y86_pkg.sv
// y86_pkg
// Shared Y86 pipeline constants: instruction codes, ALU function codes,
// branch/cmov condition codes, status codes, the "no register" ID and the
// condition-code bit layout with its reset value.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // ALU function codes (ifun of OPq)
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    // Branch / cmov condition codes (ifun of jXX / cmovXX)
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    // Condition-code register layout: {ZF, SF, OF}
    localparam int         CC_ZF    = 2;
    localparam int         CC_SF    = 1;
    localparam int         CC_OF    = 0;
    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/cc_cond.sv
// cc_cond
// Purely combinational jXX/cmovXX condition evaluation from a {ZF,SF,OF}
// condition-code vector and the instruction's ifun. Also used by the
// fetch-stage branch prediction check.
// Ports:
//   cc   in  3  {ZF,SF,OF}
//   ifun in  4  condition selector
//   cnd  out 1  condition true
module cc_cond
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf;
    logic sf;
    logic of;
    logic lt;

    assign zf = cc[CC_ZF];
    assign sf = cc[CC_SF];
    assign of = cc[CC_OF];
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_cc_pipe.sv
// exec_cc_pipe
// Condition-code register and execute-to-memory pipeline register for the
// Y86 pipeline. CC is updated from OPq results; jXX/cmovXX condition is
// evaluated from the architectural CC (not from flags being written this
// cycle). The E->M bundle is loaded with bubble > stall > load priority.
// Optional build macro: EXEC_CMOV_SQUASH_EN -- when defined, a cmovXX whose
// condition is false has its dstE replaced by RNONE here; otherwise dstE is
// passed through and writeback squashes using M_cnd.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   e_valid, e_icode, e_ifun   execute-stage instruction
//   alu_a, alu_b, alu_out      ALU operands and result (valE = B op A)
//   e_valA, e_dstE, e_dstM     pass-through data and destinations
//   e_stat                     instruction status
//   set_cc, cc_hold            CC update request / exception block
//   m_stall, m_bubble          E->M register control
//   cc                         {ZF,SF,OF}
//   e_cnd, e_dstE_eff          combinational condition and effective dstE
//   M_*                        registered E->M bundle
module exec_cc_pipe
    import y86_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              e_valid,
    input  logic [3:0]        e_icode,
    input  logic [3:0]        e_ifun,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] e_valA,
    input  logic [3:0]        e_dstE,
    input  logic [3:0]        e_dstM,
    input  logic [2:0]        e_stat,
    input  logic              set_cc,
    input  logic              cc_hold,
    input  logic              m_stall,
    input  logic              m_bubble,
    output logic [2:0]        cc,
    output logic              e_cnd,
    output logic [3:0]        e_dstE_eff,
    output logic              M_valid,
    output logic              M_cnd,
    output logic [3:0]        M_icode,
    output logic [DATA_W-1:0] M_valE,
    output logic [DATA_W-1:0] M_valA,
    output logic [3:0]        M_dstE,
    output logic [3:0]        M_dstM,
    output logic [2:0]        M_stat
);

    logic       a_msb;
    logic       b_msb;
    logic       out_msb;
    logic       of_new;
    logic [2:0] cc_new;
    logic       cc_we;
    logic       unused_alu_low;

    assign a_msb   = alu_a[DATA_W-1];
    assign b_msb   = alu_b[DATA_W-1];
    assign out_msb = alu_out[DATA_W-1];

    // Only the sign bits of the operands matter for overflow detection.
    assign unused_alu_low = ^{alu_a[DATA_W-2:0], alu_b[DATA_W-2:0]};

    always_comb begin
        of_new = 1'b0;
        case (e_ifun)
            ALU_ADD: of_new = (a_msb == b_msb) && (out_msb != b_msb);
            ALU_SUB: of_new = (a_msb != b_msb) && (out_msb != b_msb);
            default: of_new = 1'b0;
        endcase
    end

    always_comb begin
        cc_new        = '0;
        cc_new[CC_ZF] = (alu_out == '0);
        cc_new[CC_SF] = out_msb;
        cc_new[CC_OF] = of_new;
    end

    // Bubbling M does not block the update; stalling M does.
    assign cc_we = set_cc & e_valid & (e_stat == STAT_AOK) & ~cc_hold & ~m_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= CC_RESET;
        end else if (cc_we) begin
            cc <= cc_new;
        end
    end

    cc_cond u_cc_cond (
        .cc   (cc),
        .ifun (e_ifun),
        .cnd  (e_cnd)
    );

`ifdef EXEC_CMOV_SQUASH_EN
    assign e_dstE_eff = ((e_icode == I_CMOVXX) && !e_cnd) ? RNONE : e_dstE;
`else
    assign e_dstE_eff = e_dstE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_valid <= 1'b0;
            M_cnd   <= 1'b0;
            M_icode <= I_NOP;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
            M_stat  <= STAT_AOK;
        end else if (m_bubble || (!m_stall && !e_valid)) begin
            M_valid <= 1'b0;
            M_cnd   <= 1'b0;
            M_icode <= I_NOP;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
            M_stat  <= STAT_AOK;
        end else if (!m_stall) begin
            M_valid <= 1'b1;
            M_cnd   <= e_cnd;
            M_icode <= e_icode;
            M_valE  <= alu_out;
            M_valA  <= e_valA;
            M_dstE  <= e_dstE_eff;
            M_dstM  <= e_dstM;
            M_stat  <= e_stat;
        end
    end

endmodule

// File: tb/tb_exec_cc_pipe.sv
module tb_exec_cc_pipe;

    logic        clk;
    logic        rst_n;
    logic        e_valid;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic [31:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic [2:0]  e_stat;
    logic        set_cc;
    logic        cc_hold;
    logic        m_stall;
    logic        m_bubble;
    logic [2:0]  cc;
    logic        e_cnd;
    logic [3:0]  e_dstE_eff;
    logic        M_valid;
    logic        M_cnd;
    logic [3:0]  M_icode;
    logic [31:0] M_valE;
    logic [31:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [2:0]  M_stat;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit        r_zf, r_sf, r_of;
    bit        rm_valid, rm_cnd;
    bit [3:0]  rm_icode, rm_dstE, rm_dstM;
    bit [31:0] rm_valE, rm_valA;
    bit [2:0]  rm_stat;

    exec_cc_pipe #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .e_valid    (e_valid),
        .e_icode    (e_icode),
        .e_ifun     (e_ifun),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .e_valA     (e_valA),
        .e_dstE     (e_dstE),
        .e_dstM     (e_dstM),
        .e_stat     (e_stat),
        .set_cc     (set_cc),
        .cc_hold    (cc_hold),
        .m_stall    (m_stall),
        .m_bubble   (m_bubble),
        .cc         (cc),
        .e_cnd      (e_cnd),
        .e_dstE_eff (e_dstE_eff),
        .M_valid    (M_valid),
        .M_cnd      (M_cnd),
        .M_icode    (M_icode),
        .M_valE     (M_valE),
        .M_valA     (M_valA),
        .M_dstE     (M_dstE),
        .M_dstM     (M_dstM),
        .M_stat     (M_stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_cnd(input bit zf, input bit sf, input bit of, input bit [3:0] fn);
        bit less;
        less = (sf != of);
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return less || zf;
            4'd2:    return less;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !less;
            4'd6:    return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [3:0] ref_dste();
`ifdef EXEC_CMOV_SQUASH_EN
        if (e_icode == 4'd2 && !ref_cnd(r_zf, r_sf, r_of, e_ifun))
            return 4'hF;
`endif
        return e_dstE;
    endfunction

    // Overflow as "true signed result does not fit in 32 bits".
    function automatic bit ref_of();
        longint sa, sb, res;
        sa = longint'($signed(alu_a));
        sb = longint'($signed(alu_b));
        if (e_ifun == 4'd0)      res = sb + sa;
        else if (e_ifun == 4'd1) res = sb - sa;
        else                     return 1'b0;
        return (res > 64'sd2147483647) || (res < -64'sd2147483648);
    endfunction

    task automatic ref_bubble();
        rm_valid = 0; rm_cnd = 0; rm_icode = 4'd1; rm_valE = 0; rm_valA = 0;
        rm_dstE = 4'hF; rm_dstM = 4'hF; rm_stat = 3'd1;
    endtask

    task automatic ref_reset();
        r_zf = 1; r_sf = 0; r_of = 0;
        ref_bubble();
    endtask

    task automatic ref_edge();
        bit       cnd_now;
        bit [3:0] dste_now;
        if (!rst_n) begin
            ref_reset();
            return;
        end
        cnd_now  = ref_cnd(r_zf, r_sf, r_of, e_ifun);
        dste_now = ref_dste();
        if (m_bubble) ref_bubble();
        else if (m_stall) begin end
        else if (!e_valid) ref_bubble();
        else begin
            rm_valid = 1; rm_cnd = cnd_now; rm_icode = e_icode; rm_valE = alu_out;
            rm_valA = e_valA; rm_dstE = dste_now; rm_dstM = e_dstM; rm_stat = e_stat;
        end
        if (set_cc && e_valid && e_stat == 3'd1 && !cc_hold && !m_stall) begin
            r_zf = (alu_out == 0);
            r_sf = alu_out[31];
            r_of = ref_of();
        end
    endtask

    task automatic check_all();
        check("cc",         32'(cc),         32'({r_zf, r_sf, r_of}));
        check("e_cnd",      32'(e_cnd),      32'(ref_cnd(r_zf, r_sf, r_of, e_ifun)));
        check("e_dstE_eff", 32'(e_dstE_eff), 32'(ref_dste()));
        check("M_valid",    32'(M_valid),    32'(rm_valid));
        check("M_cnd",      32'(M_cnd),      32'(rm_cnd));
        check("M_icode",    32'(M_icode),    32'(rm_icode));
        check("M_valE",     M_valE,          rm_valE);
        check("M_valA",     M_valA,          rm_valA);
        check("M_dstE",     32'(M_dstE),     32'(rm_dstE));
        check("M_dstM",     32'(M_dstM),     32'(rm_dstM));
        check("M_stat",     32'(M_stat),     32'(rm_stat));
    endtask

    task automatic tick();
        @(posedge clk);
        ref_edge();
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        tick();
    endtask

    task automatic idle();
        e_valid = 1; e_icode = 4'd1; e_ifun = 0; alu_a = 0; alu_b = 0; alu_out = 0;
        e_valA = 0; e_dstE = 4'hF; e_dstM = 4'hF; e_stat = 3'd1;
        set_cc = 0; cc_hold = 0; m_stall = 0; m_bubble = 0;
    endtask

    task automatic opq(input bit [3:0] fn, input bit [31:0] a, input bit [31:0] b,
                       input bit [31:0] out);
        idle();
        e_icode = 4'd6; e_ifun = fn; alu_a = a; alu_b = b; alu_out = out;
        e_dstE = 4'd2; set_cc = 1;
    endtask

    function automatic bit [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_random();
        idle();
        e_valid = ($urandom_range(0, 99) < 85);
        e_icode = 4'($urandom_range(0, 11));
        e_ifun  = (e_icode == 4'd6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        alu_a   = pick_operand();
        alu_b   = ($urandom_range(0, 3) == 0) ? alu_a : pick_operand();
        case (e_ifun)
            4'd0:    alu_out = alu_b + alu_a;
            4'd1:    alu_out = alu_b - alu_a;
            4'd2:    alu_out = alu_b & alu_a;
            4'd3:    alu_out = alu_b ^ alu_a;
            default: alu_out = $urandom;
        endcase
        e_valA   = $urandom;
        e_dstE   = 4'($urandom_range(0, 15));
        e_dstM   = 4'($urandom_range(0, 15));
        e_stat   = ($urandom_range(0, 99) < 80) ? 3'd1 : 3'($urandom_range(1, 4));
        set_cc   = (e_icode == 4'd6) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
        cc_hold  = ($urandom_range(0, 9) == 0);
        m_stall  = ($urandom_range(0, 99) < 15);
        m_bubble = ($urandom_range(0, 99) < 10);
    endtask

    initial begin
        rst_n = 0;
        idle();
        ref_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_cc",      32'(cc),      32'h4);
        check("rst_M_icode", 32'(M_icode), 32'h1);
        check("rst_M_dstE",  32'(M_dstE),  32'hF);
        check("rst_M_valid", 32'(M_valid), 32'h0);
        rst_n = 1;

        // ADD overflow, then jl sees SF^OF = 0
        opq(4'd0, 32'h1, 32'h7FFFFFFF, 32'h80000000);
        step();
        idle();
        e_icode = 4'd7; e_ifun = 4'd2;
        #1;
        check("add_of_cc", 32'(cc),    32'h3);
        check("jl_cnd",    32'(e_cnd), 32'h0);
        step();

        // SUB to zero, je / jne
        opq(4'd1, 32'd5, 32'd5, 32'd0);
        step();
        idle();
        e_icode = 4'd7; e_ifun = 4'd3;
        #1;
        check("sub_zero_cc", 32'(cc),    32'h4);
        check("je_cnd",      32'(e_cnd), 32'h1);
        e_ifun = 4'd4;
        #1;
        check("jne_cnd",     32'(e_cnd), 32'h0);
        step();

        // cc = 000, then cc_hold blocks an update to ZF=1 but M still loads
        opq(4'd0, 32'd1, 32'd1, 32'd2);
        step();
        opq(4'd0, 32'd0, 32'd0, 32'd0);
        cc_hold = 1;
        step();
        idle();
        #1;
        check("hold_cc",     32'(cc),      32'h0);
        check("hold_M_valE", M_valE,       32'h0);
        check("hold_M_icode",32'(M_icode), 32'h6);

        // cmovle with cc = 000 -> condition false
        idle();
        e_icode = 4'd2; e_ifun = 4'd1; e_dstE = 4'd3;
        #1;
        check("cmovle_cnd", 32'(e_cnd), 32'h0);
        step();
        idle();
        #1;
`ifdef EXEC_CMOV_SQUASH_EN
        check("cmov_M_dstE", 32'(M_dstE), 32'hF);
`else
        check("cmov_M_dstE", 32'(M_dstE), 32'h3);
`endif
        check("cmov_M_cnd", 32'(M_cnd), 32'h0);

        // Stall two cycles: M and CC frozen
        idle();
        e_icode = 4'd3; alu_out = 32'h1234; e_dstE = 4'd5;
        step();
        for (int i = 0; i < 2; i++) begin
            opq(4'd0, 32'd0, 32'd0, 32'd0);
            m_stall = 1;
            step();
            #1;
            check("stall_M_valE",  M_valE,       32'h1234);
            check("stall_M_dstE",  32'(M_dstE),  32'h5);
            check("stall_cc",      32'(cc),      32'h0);
        end

        // Stall and bubble together: bubble wins, CC still frozen
        opq(4'd0, 32'd0, 32'd0, 32'd0);
        m_stall = 1; m_bubble = 1;
        step();
        idle();
        #1;
        check("sb_M_valid", 32'(M_valid), 32'h0);
        check("sb_M_icode", 32'(M_icode), 32'h1);
        check("sb_M_dstE",  32'(M_dstE),  32'hF);
        check("sb_cc",      32'(cc),      32'h0);

        // Bubble with set_cc: CC still updates
        opq(4'd1, 32'd7, 32'd7, 32'd0);
        m_bubble = 1;
        step();
        idle();
        #1;
        check("bub_cc",      32'(cc),      32'h4);
        check("bub_M_valid", 32'(M_valid), 32'h0);

        // Randomized traffic with a mid-run asynchronous reset
        for (int n = 0; n < 600; n++) begin
            drive_random();
            if (n == 300) begin
                @(negedge clk);
                #2;
                rst_n = 0;
                #1;
                ref_reset();
                check("async_rst_cc",     32'(cc),      32'h4);
                check("async_rst_M_valid",32'(M_valid), 32'h0);
                check("async_rst_M_dstM", 32'(M_dstM),  32'hF);
                tick();
                rst_n = 1;
            end else begin
                step();
            end
        end
        @(negedge clk);
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_cc_pipe.md
# exec_cc_pipe

Condition-code and execute-to-memory boundary block for the Y86 pipeline, sitting directly downstream of the execute-stage ALU. It holds the architectural condition codes (ZF, SF, OF) and updates them from each OPq result. It evaluates the branch/cmov condition `cnd` for jXX/cmovXX, and registers the E→M bundle with stall/bubble control for the memory stage.

## Interface
- `DATA_W`, 32, ALU/operand datapath width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `e_valid`  in  1  execute stage holds a real instruction
- `e_icode`  in  4  instruction code
- `e_ifun`  in  4  function code
- `alu_a`  in  DATA_W  ALU operand A
- `alu_b`  in  DATA_W  ALU operand B
- `alu_out`  in  DATA_W  ALU result (valE = B op A)
- `e_valA`  in  DATA_W  store data / pass-through
- `e_dstE`, `e_dstM`  in  4  destination register IDs
- `e_stat`  in  3  status code
- `set_cc`  in  1  control: current instruction updates CC
- `cc_hold`  in  1  exception in M/W; blocks CC update
- `m_stall`  in  1  hold E→M register
- `m_bubble`  in  1  inject NOP into E→M register
- `cc`  out  3  {ZF,SF,OF} current register value
- `e_cnd`  out  1  combinational condition result
- `e_dstE_eff`  out  4  dstE after cmov squash, combinational
- `M_valid`, `M_cnd`  out  1  registered
- `M_icode`  out  4  registered
- `M_valE`, `M_valA`  out  DATA_W  registered
- `M_dstE`, `M_dstM`  out  4  registered
- `M_stat`  out  3  registered

## Operation
- Flags from `alu_out`:
  - ZF = (alu_out == 0)
  - SF = alu_out[DATA_W-1]
- OF by `e_ifun`:
  - ADD (0): a_msb == b_msb and out_msb != b_msb
  - SUB (1): a_msb != b_msb and out_msb != b_msb
  - AND (2), XOR (3): OF = 0
- CC write enable = set_cc & e_valid & (e_stat == AOK) & ~cc_hold & ~m_stall.
- `e_cnd` is evaluated from the current `cc` register, never from the flags being written. By `e_ifun`:
  - 0: 1
  - 1 LE: (SF^OF)|ZF
  - 2 L: SF^OF
  - 3 E: ZF
  - 4 NE: ~ZF
  - 5 GE: ~(SF^OF)
  - 6 G: ~(SF^OF)&~ZF
  - 7–15: 0
- E→M register update priority: m_bubble > m_stall > load.
  - Bubble: valid=0, icode=NOP(1), stat=AOK(1), dstE=dstM=RNONE(0xF), cnd/valE/valA=0.
  - Stall: all M_* hold.
  - Load: M_* ← e_* with M_dstE ← e_dstE_eff and M_cnd ← e_cnd.
- `e_valid`=0 with no stall/bubble loads the bubble pattern.

## Timing
- Reset (asynchronous, rst_n low): cc = 3'b100 (ZF=1, SF=0, OF=0). All M_* take the bubble pattern. Reset mid-operation discards in-flight state immediately.
- `e_cnd` and `e_dstE_eff` are zero-latency combinational outputs.
- `cc` and M_* update one cycle after the qualifying edge; latency E→M is 1 clock.
- CC and the register are both frozen under m_stall. A bubble with set_cc high still updates CC if the other enable terms hold; CC update is decoupled from M bubbling.
- m_stall and m_bubble asserted together: bubble wins.
- Arithmetic is modulo 2^DATA_W; no width extension.

## Configuration
- `EXEC_CMOV_SQUASH_EN` defined: when icode == CMOVXX (2) and e_cnd == 0, e_dstE_eff = RNONE (0xF).
- Not defined: e_dstE_eff = e_dstE always. The downstream writeback then performs the squash using M_cnd.

## Structure
- Shared package `y86_pkg`:
  - icode constants (NOP, HALT, CMOVXX, OPQ, JXX, …)
  - ALU ifun codes
  - stat codes: AOK=1, HLT=2, ADR=3, INS=4
  - RNONE = 4'hF
  - CC bit indices, CC reset constant
- One sub-module, `cc_cond`: combinational {cc, ifun} → cnd. Reused by fetch-stage branch prediction checks.

## Test plan
- Reset: rst_n low → cc=3'b100, M_icode=1, M_dstE=0xF, M_valid=0.
- OF on ADD: e_ifun=0, alu_b=0x7FFFFFFF, alu_a=1, alu_out=0x80000000, set_cc=1 → next cycle cc={0,1,1}; a following jl (ifun 2) gives e_cnd=0.
- SUB to zero: e_ifun=1, alu_b=5, alu_a=5, alu_out=0 → cc={1,0,0}; je gives cnd=1, jne gives cnd=0.
- cc_hold=1 with ADD result 0 → cc unchanged; M_valE=0 still loaded.
- cmovle with cc={0,0,0}, e_dstE=3:
  - With EXEC_CMOV_SQUASH_EN: M_dstE=0xF, M_cnd=0.
  - Without the macro: M_dstE=3.
- Pipeline control:
  - m_stall for 2 cycles → M_* hold their values.
  - m_stall=m_bubble=1 → bubble pattern loaded and cc unchanged.
